// File: rtl/interrupt_arbiter_pkg.sv
// Shared cause codes, priority order and state encoding for the interrupt arbiter.
// Cause numbering follows the RISC-V mcause interrupt codes.
package interrupt_arbiter_pkg;

  localparam logic [3:0] CAUSE_SSI = 4'd1;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_STI = 4'd5;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_SEI = 4'd9;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int NUM_CAUSES = 12;
  localparam int NUM_RANKS  = 6;

  // Bits of the 12-bit cause vectors that carry a real source.
  localparam logic [11:0] USED_MASK    = 12'hAAA;
  // Sources that only exist when supervisor mode is built in.
  localparam logic [11:0] S_CAUSE_MASK = 12'h222;

  // Index 0 is the highest priority.
  localparam logic [3:0] PRIO_ORDER [NUM_RANKS] = '{
    CAUSE_MEI, CAUSE_MSI, CAUSE_MTI, CAUSE_SEI, CAUSE_SSI, CAUSE_STI
  };

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKOUT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/interrupt_priority_select.sv
// Fixed-priority pick among eligible causes; any M-level cause beats any S-level cause.
module interrupt_priority_select
  import interrupt_arbiter_pkg::*;
(
  input  logic [11:0] m_mask,
  input  logic [11:0] s_mask,
  output logic        valid,
  output logic [3:0]  cause,
  output logic        to_s
);

  logic [NUM_RANKS-1:0] m_hit;
  logic [NUM_RANKS-1:0] s_hit;
  logic                 unused_mask_bits;

  // Only six bits of each mask are meaningful; fold the rest away.
  assign unused_mask_bits = ^{m_mask & ~USED_MASK, s_mask & ~USED_MASK};

  for (genvar gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
    assign m_hit[gi] = m_mask[PRIO_ORDER[gi]];
    assign s_hit[gi] = s_mask[PRIO_ORDER[gi]];
  end

  always_comb begin
    valid = (|m_hit) | (|s_hit);
    cause = 4'd0;
    to_s  = 1'b0;
    // Walk lowest rank first so the highest-ranked hit is written last.
    for (int i = NUM_RANKS - 1; i >= 0; i--) begin
      if (s_hit[i]) begin
        cause = PRIO_ORDER[i];
        to_s  = 1'b1;
      end
    end
    for (int i = NUM_RANKS - 1; i >= 0; i--) begin
      if (m_hit[i]) begin
        cause = PRIO_ORDER[i];
        to_s  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Gathers interrupt sources, applies the CSR enables and presents one frozen,
// registered request to the global-control unit until it is taken or withdrawn.
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter bit          INCLUDE_S_MODE = 1'b0,
  parameter logic [11:0] EDGE_SENSITIVE = 12'h000,
  parameter int          LOCKOUT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] irq_lines,
  input  logic [11:0] mie,
  input  logic [11:0] mideleg,
  input  logic        mstatus_mie,
  input  logic        mstatus_sie,
  input  logic [1:0]  priv,
  input  logic        processing_csr,
  input  logic [11:0] edge_clear,
  input  logic        interrupt_taken,
  output logic        interrupt_pending,
  output logic [3:0]  interrupt_cause,
  output logic        interrupt_to_s,
  output logic        wfi_wakeup
);

  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [11:0] EDGE_MASK = EDGE_SENSITIVE & USED_MASK;

  arb_state_e       state_reg;
  logic             pending_reg;
  logic [3:0]       cause_reg;
  logic             to_s_reg;
  logic [CNT_W-1:0] lock_cnt_reg;

  logic [11:0] irq_prev_reg;
  logic [11:0] edge_latch_reg;
  logic [11:0] edge_latch_next;
  logic [11:0] irq_rise;
  logic [11:0] source;
  logic [11:0] raised;
  logic [11:0] s_level;
  logic [11:0] m_allowed;
  logic [11:0] m_elig;
  logic [11:0] s_elig;
  logic [11:0] cause_onehot;
  logic [11:0] take_clear;
  logic        take_fire;
  logic        frozen_elig;
  logic        m_enable;
  logic        s_enable;
  logic        sel_valid;
  logic [3:0]  sel_cause;
  logic        sel_to_s;

  // Source values: edge causes come from the latch, level causes straight from the pins.
  assign irq_rise = irq_lines & ~irq_prev_reg;
  assign source   = (edge_latch_reg & EDGE_MASK) | (irq_lines & ~EDGE_MASK);
  assign raised   = source & mie & USED_MASK;

  assign m_enable = (priv != PRIV_M) | mstatus_mie;
  assign s_enable = (priv == PRIV_U) | ((priv == PRIV_S) & mstatus_sie);

  assign s_level   = INCLUDE_S_MODE ? (mideleg & USED_MASK) : 12'h000;
  assign m_allowed = INCLUDE_S_MODE ? USED_MASK : (USED_MASK & ~S_CAUSE_MASK);

  assign m_elig = raised & ~s_level & m_allowed & {12{m_enable}};
  assign s_elig = raised & s_level & {12{s_enable}};

  assign wfi_wakeup = |raised;

  for (genvar gi = 0; gi < NUM_CAUSES; gi++) begin : g_onehot
    assign cause_onehot[gi] = (cause_reg == 4'(gi));
  end

  assign take_fire   = (state_reg == ARMED) & interrupt_taken;
  assign take_clear  = cause_onehot & {12{take_fire}};
  assign frozen_elig = |((m_elig | s_elig) & cause_onehot);

  // A rising edge in the same cycle outranks both software and take clears.
  assign edge_latch_next =
    ((edge_latch_reg & ~(edge_clear | take_clear)) | irq_rise) & EDGE_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_reg   <= 12'h000;
      edge_latch_reg <= 12'h000;
    end else begin
      irq_prev_reg   <= irq_lines;
      edge_latch_reg <= edge_latch_next;
    end
  end

  interrupt_priority_select u_select (
    .m_mask (m_elig),
    .s_mask (s_elig),
    .valid  (sel_valid),
    .cause  (sel_cause),
    .to_s   (sel_to_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= 1'b0;
      cause_reg    <= 4'd0;
      to_s_reg     <= 1'b0;
      lock_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_valid && !processing_csr) begin
            state_reg   <= ARMED;
            pending_reg <= 1'b1;
            cause_reg   <= sel_cause;
            to_s_reg    <= sel_to_s;
          end
        end
        ARMED: begin
          // Take beats withdraw; cause stays frozen while armed.
          if (interrupt_taken) begin
            state_reg    <= LOCKOUT;
            pending_reg  <= 1'b0;
            lock_cnt_reg <= '0;
          end else if (!frozen_elig) begin
            state_reg   <= IDLE;
            pending_reg <= 1'b0;
          end
        end
        LOCKOUT: begin
          // Gives trap-entry mstatus updates time to land before re-arming.
          if (lock_cnt_reg == LOCK_LAST) begin
            state_reg <= IDLE;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_pending = pending_reg;
  assign interrupt_cause   = cause_reg;
  assign interrupt_to_s    = to_s_reg;

endmodule
